hand_timekeeper: RTL and testbench
==================================

Name: hand_timekeeper

Overview:
- Owns wall-clock time for the VGA clock face and drives the second, minute and hour tick positions (0..59) consumed by the hand rotators.
- Accepts time-set words from the SPI receiver via a valid/ready handshake, with range checking.
- Generates the 1 Hz advance from the system clock.
- Publishes hand positions only at frame boundaries, so a hand never changes mid-frame.

Parameters:
- CLK_HZ, 40000000, system clock cycles per second; prescaler terminal count is CLK_HZ-1.
- STALE_SECS, 3600, seconds without an accepted sync before the time is declared stale.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- sync_valid  in  1  time-set word present
- sync_ready  out  1  block can accept a word this cycle
- sync_hour  in  5  hour 0..11
- sync_min  in  6  minute 0..59
- sync_sec  in  6  second 0..59
- frame_start  in  1  one-cycle pulse per video frame, already synchronised to clk
- second_tick  out  6  second-hand position 0..59
- minute_tick  out  6  minute-hand position 0..59
- hour_tick  out  6  hour-hand position 0..59
- hands_valid  out  1  time has been set and is not stale
- since_sync  out  16  seconds since last accepted sync, saturating at 65535
- sync_err  out  1  one-cycle pulse: out-of-range word rejected

Behaviour:
- Reset values (async, reset_n low):
  - hh/mm/ss = 0, prescaler = 0.
  - All tick outputs = 0, hands_valid = 0, since_sync = 0, sync_err = 0, sync_ready = 0.
  - FSM = UNSET.
- sync_ready is 1 in every state except the first cycle after reset deassertion.
- Acceptance:
  - A word is accepted on any cycle with sync_valid & sync_ready.
  - Range check: hour<12, min<60, sec<60.
  - Fail: sync_err pulses 1 the next cycle; state and time are unchanged.
  - Pass: on the next edge, hh/mm/ss are loaded, prescaler = 0, since_sync = 0, FSM goes to SET.
- Prescaler:
  - Counts 0..CLK_HZ-1 and wraps.
  - sec_pulse is internal, high on the cycle the count equals CLK_HZ-1.
- On sec_pulse:
  - ss increments; ss 59 wraps to 0 and carries into mm.
  - mm 59 wraps to 0 and carries into hh.
  - hh 11 wraps to 0 (12-hour face).
  - since_sync increments, saturating at 65535.
  - Time runs in every state, including UNSET.
- Simultaneous accept and sec_pulse: the load wins and no increment occurs that cycle.
- FSM:
  - UNSET -> SET on a valid accept.
  - SET -> STALE when since_sync reaches STALE_SECS.
  - STALE -> SET on a valid accept.
  - hands_valid = 1 only in SET.
- Display shadow:
  - second_tick/minute_tick/hour_tick register the live values only on cycles with frame_start = 1; otherwise they hold.
  - second_tick = ss, minute_tick = mm.
  - hour_tick = hh*5 (+ smoothing, see Optional Feature).
  - Latency: one clk from the frame_start edge to the updated outputs.
  - A load or increment in the same cycle as frame_start is not visible until the next frame_start.
- Arithmetic:
  - hh*5 uses a 6-bit result, max 55.
  - mm/12 uses a constant divide, result 0..4.
  - Sum is at most 59, so no overflow.
- Reset asserted mid-operation clears everything immediately; no pending word survives.

Optional Feature:
- Macro: HOUR_SMOOTH_EN.
- Defined: hour_tick = hh*5 + mm/12, so the hour hand creeps between hour marks.
- Undefined: hour_tick = hh*5; the hour hand jumps once per hour and the divider is not synthesised.

Test Plan (bench uses CLK_HZ=10, STALE_SECS=5):
- Reset, then 25 cycles with frame_start every 5 cycles -> hands_valid = 0; second_tick reaches 2; hh/mm unchanged = 0.
- Sync 11:59:58 accepted, then frame_start after 30 cycles -> second_tick=1, minute_tick=0, hour_tick=0; hands_valid = 1.
- Sync 3:24:10 with HOUR_SMOOTH_EN, then frame_start -> hour_tick=17 (15 without the macro), minute_tick=24, second_tick=10.
- Sync with min=60 -> sync_err is a single pulse; ticks and FSM are unchanged; since_sync keeps counting.
- Sync accepted exactly on a sec_pulse cycle -> loaded seconds value unchanged, since_sync = 0, prescaler restarts at 0.
- No sync for 50 cycles after a set -> state STALE, hands_valid = 0 at since_sync=5; a new valid sync returns hands_valid to 1.

Source files
------------

// File: rtl/hand_timekeeper.sv
// Wall-clock timekeeper for the clock face: 1 Hz prescaler, validated time-set handshake and frame-aligned hand positions.
// Build option: define HOUR_SMOOTH_EN to let the hour hand creep by minute (hh*5 + mm/12).
module hand_timekeeper #(
  parameter int CLK_HZ     = 40000000,
  parameter int STALE_SECS = 3600
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sync_valid,
  output logic        sync_ready,
  input  logic [4:0]  sync_hour,
  input  logic [5:0]  sync_min,
  input  logic [5:0]  sync_sec,
  input  logic        frame_start,
  output logic [5:0]  second_tick,
  output logic [5:0]  minute_tick,
  output logic [5:0]  hour_tick,
  output logic        hands_valid,
  output logic [15:0] since_sync,
  output logic        sync_err
);

  localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);

  typedef enum logic [1:0] {
    ST_UNSET,
    ST_SET,
    ST_STALE
  } state_t;

  state_t              state_reg;
  logic [PRESC_W-1:0]  presc_reg;
  logic [5:0]          ss_reg;
  logic [5:0]          mm_reg;
  logic [3:0]          hh_reg;
  logic [15:0]         since_reg;
  logic                sync_ready_reg;
  logic                sync_err_reg;
  logic                hands_valid_reg;
  logic [5:0]          second_tick_reg;
  logic [5:0]          minute_tick_reg;
  logic [5:0]          hour_tick_reg;

  logic                sec_pulse;
  logic                accept;
  logic                word_ok;
  logic                load;
  logic                reject;
  logic [5:0]          ss_next;
  logic [5:0]          mm_next;
  logic [3:0]          hh_next;
  logic [15:0]         since_inc;
  logic                stale_hit;
  logic [5:0]          hh_x5;
  logic [5:0]          hour_pos;

  assign sec_pulse = (presc_reg == PRESC_LAST);
  assign accept    = sync_valid & sync_ready_reg;
  assign word_ok   = (sync_hour < 5'd12) && (sync_min < 6'd60) && (sync_sec < 6'd60);
  assign load      = accept & word_ok;
  assign reject    = accept & ~word_ok;

  always_comb begin
    ss_next = ss_reg + 6'd1;
    mm_next = mm_reg;
    hh_next = hh_reg;
    if (ss_reg == 6'd59) begin
      ss_next = 6'd0;
      if (mm_reg == 6'd59) begin
        mm_next = 6'd0;
        hh_next = (hh_reg == 4'd11) ? 4'd0 : hh_reg + 4'd1;
      end else begin
        mm_next = mm_reg + 6'd1;
      end
    end
  end

  assign since_inc = (since_reg == 16'hFFFF) ? since_reg : since_reg + 16'd1;
  // Judged on the post-increment count so the hands drop on the same edge since_sync hits the limit.
  assign stale_hit = (int'(since_inc) >= STALE_SECS);

  assign hh_x5 = {hh_reg, 2'b00} + {2'b00, hh_reg};
`ifdef HOUR_SMOOTH_EN
  assign hour_pos = hh_x5 + 6'(mm_reg / 6'd12);
`else
  assign hour_pos = hh_x5;
`endif

  // A valid load always beats a coincident second increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_UNSET;
      presc_reg       <= '0;
      ss_reg          <= 6'd0;
      mm_reg          <= 6'd0;
      hh_reg          <= 4'd0;
      since_reg       <= 16'd0;
      sync_ready_reg  <= 1'b0;
      sync_err_reg    <= 1'b0;
      hands_valid_reg <= 1'b0;
    end else begin
      sync_ready_reg <= 1'b1;
      sync_err_reg   <= reject;
      if (load) begin
        hh_reg          <= sync_hour[3:0];
        mm_reg          <= sync_min;
        ss_reg          <= sync_sec;
        presc_reg       <= '0;
        since_reg       <= 16'd0;
        state_reg       <= ST_SET;
        hands_valid_reg <= 1'b1;
      end else begin
        presc_reg <= sec_pulse ? '0 : presc_reg + 1'b1;
        if (sec_pulse) begin
          ss_reg    <= ss_next;
          mm_reg    <= mm_next;
          hh_reg    <= hh_next;
          since_reg <= since_inc;
          if (state_reg == ST_SET && stale_hit) begin
            state_reg       <= ST_STALE;
            hands_valid_reg <= 1'b0;
          end
        end
      end
    end
  end

  // Shadow copies for the rotators; refreshed only at frame boundaries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      second_tick_reg <= 6'd0;
      minute_tick_reg <= 6'd0;
      hour_tick_reg   <= 6'd0;
    end else if (frame_start) begin
      second_tick_reg <= ss_reg;
      minute_tick_reg <= mm_reg;
      hour_tick_reg   <= hour_pos;
    end
  end

  assign sync_ready  = sync_ready_reg;
  assign sync_err    = sync_err_reg;
  assign hands_valid = hands_valid_reg;
  assign since_sync  = since_reg;
  assign second_tick = second_tick_reg;
  assign minute_tick = minute_tick_reg;
  assign hour_tick   = hour_tick_reg;

endmodule

// File: tb/tb_hand_timekeeper.sv
// Bench for hand_timekeeper: reference model tracks time as total seconds on a 12-hour face.
module tb_hand_timekeeper;
  localparam int CLK_HZ     = 10;
  localparam int STALE_SECS = 5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sync_valid = 1'b0;
  logic        sync_ready;
  logic [4:0]  sync_hour = '0;
  logic [5:0]  sync_min = '0;
  logic [5:0]  sync_sec = '0;
  logic        frame_start = 1'b0;
  logic [5:0]  second_tick;
  logic [5:0]  minute_tick;
  logic [5:0]  hour_tick;
  logic        hands_valid;
  logic [15:0] since_sync;
  logic        sync_err;

  hand_timekeeper #(.CLK_HZ(CLK_HZ), .STALE_SECS(STALE_SECS)) dut (
    .clk(clk), .reset_n(reset_n),
    .sync_valid(sync_valid), .sync_ready(sync_ready),
    .sync_hour(sync_hour), .sync_min(sync_min), .sync_sec(sync_sec),
    .frame_start(frame_start),
    .second_tick(second_tick), .minute_tick(minute_tick), .hour_tick(hour_tick),
    .hands_valid(hands_valid), .since_sync(since_sync), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: m_t seconds into the 12 h face, m_pc cycles into the current second, m_state 0 unset / 1 set / 2 stale
  int m_t, m_pc, m_since, m_state, m_st, m_mt, m_ht;
  bit m_err, m_ready;

  logic [36:0] dut_vec;
  assign dut_vec = {second_tick, minute_tick, hour_tick, hands_valid, since_sync, sync_err, sync_ready};

  function automatic int hour_pos(input int t);
    int p;
    p = (t / 3600) * 5;
`ifdef HOUR_SMOOTH_EN
    p = p + ((t / 60) % 60) / 12;
`endif
    return p;
  endfunction

  function automatic logic [36:0] exp_vec();
    return {6'(m_st), 6'(m_mt), 6'(m_ht), 1'(m_state == 1), 16'(m_since), 1'(m_err), 1'(m_ready)};
  endfunction

  task automatic model_reset();
    m_t = 0; m_pc = 0; m_since = 0; m_state = 0;
    m_st = 0; m_mt = 0; m_ht = 0; m_err = 0; m_ready = 0;
  endtask

  // Drive one cycle of inputs, advance the model, land 1 ns after the edge.
  task automatic step(input bit v, input int h, input int mn, input int s, input bit fs);
    bit acc, ok, tick;
    sync_valid = v; sync_hour = 5'(h); sync_min = 6'(mn); sync_sec = 6'(s); frame_start = fs;
    acc  = v && m_ready;
    ok   = (h < 12) && (mn < 60) && (s < 60);
    tick = (m_pc == CLK_HZ - 1);
    @(posedge clk);
    #1;
    if (fs) begin
      m_st = m_t % 60; m_mt = (m_t / 60) % 60; m_ht = hour_pos(m_t);
    end
    m_err = acc && !ok;
    if (acc && ok) begin
      m_t = h * 3600 + mn * 60 + s; m_pc = 0; m_since = 0; m_state = 1;
    end else begin
      m_pc = (m_pc + 1) % CLK_HZ;
      if (tick) begin
        m_t = (m_t + 1) % 43200;
        if (m_since < 65535) m_since = m_since + 1;
        if (m_state == 1 && m_since >= STALE_SECS) m_state = 2;
      end
    end
    m_ready = 1;
    sync_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_async: got %h expected %h", dut_vec, exp_vec());
    end
    @(posedge clk); #1;
    checks++;
    if (dut_vec !== 37'd0) begin
      errors++; $display("FAIL reset_hold: got %h expected %h", dut_vec, 37'd0);
    end
    #2 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    step(1, 3, 4, 5, 0);
    checks++;
    if (sync_ready !== 1'b1 || hands_valid !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL first_cycle_ignore: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_free_run();
    do_reset();
    for (int i = 1; i <= 25; i++) begin
      step(0, 0, 0, 0, (i % 5) == 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL free_run cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (second_tick !== 6'd2 || minute_tick !== 6'd0 || hour_tick !== 6'd0 || hands_valid !== 1'b0) begin
      errors++;
      $display("FAIL free_run_end: got s=%0d m=%0d h=%0d hv=%0d required s=2 m=0 h=0 hv=0",
               second_tick, minute_tick, hour_tick, hands_valid);
    end
  endtask

  task automatic test_sync_wrap();
    step(1, 11, 59, 58, 0);
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 0, 0, 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL sync_wrap cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (second_tick !== 6'd1 || minute_tick !== 6'd0 || hour_tick !== 6'd0 || hands_valid !== 1'b1) begin
      errors++;
      $display("FAIL sync_wrap_end: got s=%0d m=%0d h=%0d hv=%0d required s=1 m=0 h=0 hv=1",
               second_tick, minute_tick, hour_tick, hands_valid);
    end
  endtask

  task automatic test_smooth();
    int exp_h;
`ifdef HOUR_SMOOTH_EN
    exp_h = 17;
`else
    exp_h = 15;
`endif
    step(1, 3, 24, 10, 0);
    step(0, 0, 0, 0, 1);
    checks++;
    if (hour_tick !== 6'(exp_h) || minute_tick !== 6'd24 || second_tick !== 6'd10) begin
      errors++;
      $display("FAIL smooth: got h=%0d m=%0d s=%0d required h=%0d m=24 s=10",
               hour_tick, minute_tick, second_tick, exp_h);
    end
  endtask

  task automatic test_range_error();
    logic [17:0] ticks_before;
    ticks_before = {second_tick, minute_tick, hour_tick};
    step(1, 5, 60, 0, 0);
    checks++;
    if (sync_err !== 1'b1 || hands_valid !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL range_err_pulse: got %h expected %h", dut_vec, exp_vec());
    end
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0, 0);
      checks++;
      if (sync_err !== 1'b0 || {second_tick, minute_tick, hour_tick} !== ticks_before
          || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL range_err_after cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_sec_pulse_sync();
    for (int i = 0; i < 2 * CLK_HZ && m_pc != CLK_HZ - 1; i++) step(0, 0, 0, 0, 0);
    step(1, 7, 30, 45, 0);
    checks++;
    if (since_sync !== 16'd0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL pulse_sync_load: got %h expected %h", dut_vec, exp_vec());
    end
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    checks++;
    if (second_tick !== 6'd45) begin
      errors++; $display("FAIL pulse_sync_hold: got s=%0d required s=45", second_tick);
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (second_tick !== 6'd46 || since_sync !== 16'd1) begin
      errors++; $display("FAIL pulse_sync_restart: got s=%0d since=%0d required s=46 since=1",
                         second_tick, since_sync);
    end
  endtask

  task automatic test_stale();
    step(1, 1, 2, 3, 0);
    for (int i = 1; i <= 50; i++) begin
      step(0, 0, 0, 0, 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL stale cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (hands_valid !== 1'b0 || since_sync !== 16'd5) begin
      errors++; $display("FAIL stale_end: got hv=%0d since=%0d required hv=0 since=5", hands_valid, since_sync);
    end
    step(1, 9, 0, 0, 0);
    checks++;
    if (hands_valid !== 1'b1 || since_sync !== 16'd0) begin
      errors++; $display("FAIL stale_resync: got hv=%0d since=%0d required hv=1 since=0", hands_valid, since_sync);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      step($urandom_range(0, 7) == 0, $urandom_range(0, 15), $urandom_range(0, 63),
           $urandom_range(0, 63), $urandom_range(0, 3) == 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_free_run();
    test_sync_wrap();
    test_smooth();
    test_range_error();
    test_sec_pulse_sync();
    test_stale();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
